// File: rtl/obp_pkg.sv
// Shared types and constants for the one-bit-processor sequencer.
package obp_pkg;

    localparam int INSTR_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } obp_state_t;

    localparam logic [2:0] OBP_ST_NONE      = 3'd0;
    localparam logic [2:0] OBP_ST_HALTED    = 3'd1;
    localparam logic [2:0] OBP_ST_TIMEOUT   = 3'd2;
    localparam logic [2:0] OBP_ST_UNDERFLOW = 3'd3;
    localparam logic [2:0] OBP_ST_OVERFLOW  = 3'd4;
    localparam logic [2:0] OBP_ST_ABORTED   = 3'd5;

    // All-zero instruction: NOP / halt.
    localparam logic [INSTR_W-1:0] OBP_NOP_WORD = '0;

endpackage

// File: rtl/obp_serializer.sv
// LSB-first word serializer. next_bit is the bit the processor sees in the
// following cycle; sr holds the bits still to be emitted after that one.
module obp_serializer
    import obp_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] data,
    output logic         next_bit,
    output logic         bit_last
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  sr;
    logic [CW-1:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= W'(OBP_NOP_WORD);
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= {1'b0, data[W-1:1]};
            bit_cnt <= '0;
        end else if (shift) begin
            sr      <= {1'b0, sr[W-1:1]};
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    assign next_bit = load ? data[0] : sr[0];
    assign bit_last = (bit_cnt == CW'(W - 1));

endmodule

// File: rtl/obp_sequencer.sv
// Loads a program into the one-bit processor over its bit-serial port, runs it
// until halt/budget/abort, captures the output and parks the processor in reset.
module obp_sequencer
    import obp_pkg::*;
#(
    parameter int INSTR_W   = obp_pkg::INSTR_W,
    parameter int MEM_DEPTH = 1000,
    parameter int HALT_BIT  = 6,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic [INSTR_W-1:0] word_data,
    input  logic               word_last,
    input  logic [CNT_W-1:0]   run_limit,
    input  logic               abort,
    input  logic [1:0]         user_in,
    input  logic [6:0]         proc_out,
    output logic               proc_en,
    output logic               proc_reset,
    output logic [1:0]         proc_in,
    output logic               busy,
    output logic [6:0]         result,
    output logic               result_valid,
    output logic [2:0]         status,
    output logic [CNT_W-1:0]   cycles,
    output logic [1:0]         state_dbg
);

    localparam int WC_W = $clog2(MEM_DEPTH + 1);

    obp_state_t        state;
    logic [WC_W-1:0]   word_cnt;
    logic              last_q;
    logic [CNT_W-1:0]  limit_q;
    logic              next_bit, bit_last;
    logic              boundary, mem_full, hs, stop;
    logic [2:0]        stop_code;

    // Stream handshake: a word transfers in any cycle with word_valid && word_ready;
    // word_data/word_last are sampled only then, and word_valid may drop freely.
    assign boundary   = (state == ST_LOAD) && bit_last && !last_q;
    assign mem_full   = (word_cnt == WC_W'(MEM_DEPTH));
    assign word_ready = (state == ST_IDLE) || (boundary && !mem_full);
    assign hs         = word_valid && word_ready;
    assign state_dbg  = state;

    always_comb begin
        stop      = 1'b0;
        stop_code = OBP_ST_NONE;
        case (state)
            ST_LOAD: begin
                if (abort) begin
                    stop = 1'b1; stop_code = OBP_ST_ABORTED;
                end else if (boundary && !word_valid) begin
                    stop = 1'b1; stop_code = OBP_ST_UNDERFLOW;
                end else if (boundary && mem_full) begin
                    stop = 1'b1; stop_code = OBP_ST_OVERFLOW;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    stop = 1'b1; stop_code = OBP_ST_ABORTED;
                end else if (proc_out[HALT_BIT]) begin
                    stop = 1'b1; stop_code = OBP_ST_HALTED;
                end else if (limit_q != '0 && cycles + CNT_W'(1) == limit_q) begin
                    stop = 1'b1; stop_code = OBP_ST_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    obp_serializer #(.W(INSTR_W)) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (hs && !stop),
        .shift    (state == ST_LOAD),
        .data     (word_data),
        .next_bit (next_bit),
        .bit_last (bit_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            proc_reset   <= 1'b1;
            proc_en      <= 1'b0;
            proc_in      <= 2'b00;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            status       <= OBP_ST_NONE;
            cycles       <= '0;
            word_cnt     <= '0;
            last_q       <= 1'b0;
            limit_q      <= '0;
        end else begin
            result_valid <= 1'b0;
            if (stop) begin
                state        <= ST_DONE;
                status       <= stop_code;
                result       <= proc_out;
                result_valid <= 1'b1;
                proc_reset   <= 1'b1;
                proc_en      <= 1'b0;
                proc_in      <= 2'b00;
                if (state == ST_RUN) cycles <= cycles + CNT_W'(1);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (word_valid) begin
                            state      <= ST_LOAD;
                            busy       <= 1'b1;
                            proc_reset <= 1'b0;
                            proc_en    <= 1'b1;
                            proc_in    <= {1'b0, next_bit};
                            last_q     <= word_last;
                            limit_q    <= run_limit;
                            cycles     <= '0;
                            word_cnt   <= WC_W'(1);
                        end
                    end
                    ST_LOAD: begin
                        if (!bit_last) begin
                            proc_in <= {1'b0, next_bit};
                        end else if (last_q) begin
                            state   <= ST_RUN;
                            proc_en <= 1'b0;
                            proc_in <= user_in;
                        end else begin
                            // Back-to-back word: no gap in the bit stream.
                            proc_in  <= {1'b0, next_bit};
                            word_cnt <= word_cnt + WC_W'(1);
                            last_q   <= word_last;
                        end
                    end
                    ST_RUN: begin
                        cycles  <= cycles + CNT_W'(1);
                        proc_in <= user_in;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obp_sequencer.sv
// Self-checking bench for obp_sequencer: vector table of whole programs plus
// hand-written underflow, overflow and mid-load reset sequences.
module tb_obp_sequencer;
    import obp_pkg::*;

    logic        clk = 1'b0;
    logic        reset, word_valid, word_ready, word_last, abort;
    logic [12:0] word_data;
    logic [15:0] run_limit, cycles;
    logic [1:0]  user_in, proc_in, state_dbg;
    logic [6:0]  proc_out, result;
    logic        proc_en, proc_reset, busy, result_valid;
    logic [2:0]  status;

    int checks = 0;
    int failures = 0;
    logic [25:0] exp_q[$];
    logic [25:0] exp_e;
    logic [12:0] prog[5];

    typedef struct {
        int          nwords;
        logic [12:0] w0;
        logic [12:0] w1;
        logic [15:0] limit;
        int          halt_at;
        int          abort_at;
        logic [6:0]  halt_val;
        logic [6:0]  bg;
        logic [2:0]  exp_status;
        logic [15:0] exp_cycles;
        logic [6:0]  exp_result;
    } vec_t;

    vec_t tbl[7];

    obp_sequencer #(.MEM_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .word_valid(word_valid), .word_ready(word_ready),
        .word_data(word_data), .word_last(word_last), .run_limit(run_limit),
        .abort(abort), .user_in(user_in), .proc_out(proc_out), .proc_en(proc_en),
        .proc_reset(proc_reset), .proc_in(proc_in), .busy(busy), .result(result),
        .result_valid(result_valid), .status(status), .cycles(cycles),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every result_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result_valid actual=1 required=0 at %0t", $time);
            end else begin
                exp_e = exp_q.pop_front();
                check("result_sb", {6'd0, status, cycles, result}, {6'd0, exp_e});
            end
        end
    end

    // Drives cycle t (handshake) and all 13*n LOAD cycles; returns at the negedge
    // of the last LOAD cycle with that cycle's inputs still applied.
    task automatic do_load(input int n, input bit final_last, input bit offer_extra,
                           input int exp_ready);
        int ready_cnt;
        int k, b;
        logic [12:0] cur;
        ready_cnt  = 0;
        word_valid = 1'b1;
        word_data  = prog[0];
        word_last  = (n == 1) && final_last;
        for (int c = 1; c <= 13 * n; c++) begin
            next_cycle();
            k = (c - 1) / 13;
            b = (c - 1) % 13;
            if (c == 1) run_limit = 16'd2;
            word_valid = 1'b0;
            word_last  = 1'b0;
            if (b == 12 && k + 1 < n) begin
                word_valid = 1'b1;
                word_data  = prog[k+1];
                word_last  = (k + 2 == n) && final_last;
            end else if (b == 12 && offer_extra) begin
                word_valid = 1'b1;
                word_data  = prog[n];
            end
            @(negedge clk);
            cur = prog[k];
            check("load_proc_in", proc_in, {1'b0, cur[b]});
            check("load_proc_en", proc_en, 1);
            check("load_proc_reset", proc_reset, 0);
            if (word_ready) ready_cnt++;
        end
        check("load_ready_pulses", ready_cnt, exp_ready);
    endtask

    task automatic finish_done();
        next_cycle();
        word_valid = 1'b0;
        abort      = 1'b0;
        proc_out   = 7'h00;
        @(negedge clk);
        check("done_result_valid", result_valid, 1);
        check("done_proc_reset", proc_reset, 1);
        check("done_proc_en", proc_en, 0);
        check("done_word_ready", word_ready, 0);
        next_cycle();
        @(negedge clk);
        check("idle_result_valid", result_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_word_ready", word_ready, 1);
        check("idle_proc_in", proc_in, 0);
        check("idle_proc_en", proc_en, 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] prev_ui;
        prog[0]   = v.w0;
        prog[1]   = v.w1;
        run_limit = v.limit;
        user_in   = 2'b11;
        proc_out  = 7'h00;
        exp_q.push_back({v.exp_status, v.exp_cycles, v.exp_result});
        do_load(v.nwords, 1'b1, 1'b0, v.nwords - 1);
        for (int r = 1; r <= int'(v.exp_cycles); r++) begin
            next_cycle();
            word_valid = 1'b0;
            proc_out   = (v.halt_at != 0 && r >= v.halt_at) ? v.halt_val : v.bg;
            abort      = (r == v.abort_at);
            prev_ui    = user_in;
            user_in    = r[1:0];
            @(negedge clk);
            check("run_proc_en", proc_en, 0);
            check("run_proc_reset", proc_reset, 0);
            check("run_proc_in", proc_in, prev_ui);
            check("run_busy", busy, 1);
        end
        finish_done();
        check("hold_status", status, v.exp_status);
        check("hold_cycles", cycles, v.exp_cycles);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lim, h;
        reset = 1'b1; word_valid = 1'b0; word_data = '0; word_last = 1'b0;
        run_limit = '0; abort = 1'b0; user_in = 2'b00; proc_out = 7'h00;
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_proc_reset", proc_reset, 1);
        check("rst_proc_en", proc_en, 0);
        check("rst_proc_in", proc_in, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_status", status, 0);
        check("rst_cycles", cycles, 0);
        check("rst_state", state_dbg, ST_IDLE);
        next_cycle();
        reset = 1'b0;

        tbl[0] = '{2, 13'h1A35, 13'h0001, 16'd100, 5, 0, 7'h41, 7'h05, OBP_ST_HALTED, 16'd5, 7'h41};
        tbl[1] = '{1, 13'h0F0F, 13'h0000, 16'd10, 0, 0, 7'h40, 7'h2A, OBP_ST_TIMEOUT, 16'd10, 7'h2A};
        tbl[2] = '{1, 13'h1555, 13'h0000, 16'd0, 20, 0, 7'h7F, 7'h11, OBP_ST_HALTED, 16'd20, 7'h7F};
        tbl[3] = '{2, 13'h0ABC, 13'h1234, 16'd0, 0, 3, 7'h40, 7'h33, OBP_ST_ABORTED, 16'd3, 7'h33};
        tbl[4] = '{1, 13'h0001, 13'h0000, 16'd7, 7, 0, 7'h40, 7'h3F, OBP_ST_HALTED, 16'd7, 7'h40};
        for (int i = 5; i < 7; i++) begin
            lim = $urandom_range(3, 30);
            h   = $urandom_range(1, 40);
            tbl[i].nwords   = $urandom_range(1, 2);
            tbl[i].w0       = 13'($urandom);
            tbl[i].w1       = 13'($urandom);
            tbl[i].limit    = 16'(lim);
            tbl[i].halt_at  = h;
            tbl[i].abort_at = 0;
            tbl[i].halt_val = 7'h40 | 7'($urandom_range(0, 63));
            tbl[i].bg       = 7'($urandom_range(0, 63));
            if (h <= lim) begin
                tbl[i].exp_status = OBP_ST_HALTED;
                tbl[i].exp_cycles = 16'(h);
                tbl[i].exp_result = tbl[i].halt_val;
            end else begin
                tbl[i].exp_status = OBP_ST_TIMEOUT;
                tbl[i].exp_cycles = 16'(lim);
                tbl[i].exp_result = tbl[i].bg;
            end
        end

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Underflow: single non-last word, nothing offered at the boundary.
        prog[0] = 13'h0123;
        exp_q.push_back({OBP_ST_UNDERFLOW, 16'd0, 7'h00});
        do_load(1, 1'b0, 1'b0, 1);
        finish_done();
        check("underflow_status", status, OBP_ST_UNDERFLOW);

        // Overflow: five words offered back to back into a 4-word memory.
        prog[0] = 13'h1001; prog[1] = 13'h0002; prog[2] = 13'h1FFF;
        prog[3] = 13'h0800; prog[4] = 13'h1555;
        exp_q.push_back({OBP_ST_OVERFLOW, 16'd0, 7'h00});
        do_load(4, 1'b0, 1'b1, 3);
        finish_done();
        check("overflow_status", status, OBP_ST_OVERFLOW);

        // Reset in the middle of a load, then a fresh program.
        word_valid = 1'b1; word_data = 13'h0AAA; word_last = 1'b1; run_limit = '0;
        repeat (5) begin
            next_cycle();
            word_valid = 1'b0;
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_proc_reset", proc_reset, 1);
        check("midrst_proc_en", proc_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_status", status, OBP_ST_NONE);
        check("midrst_word_ready", word_ready, 1);
        check("midrst_result_valid", result_valid, 0);
        run_vec('{1, 13'h0AAA, 13'h0000, 16'd50, 4, 0, 7'h55, 7'h0C, OBP_ST_HALTED, 16'd4, 7'h55});

        repeat (3) next_cycle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obp_sequencer.md
# obp_sequencer

Controller that owns the one-bit processor's `en` / `inReg` / `reset` pins. It accepts 13-bit instruction words over a valid/ready stream and serializes them LSB-first into the processor's bit-serial load port. It then releases the processor to execute until a halt flag or a cycle budget is reached, captures the 7-bit output, and parks the processor in reset. It sits between the host/test-harness bus and the processor instance.

## Interface
- `INSTR_W`, 13: instruction width (bits shifted per word).
- `MEM_DEPTH`, 1000: maximum words per program.
- `HALT_BIT`, 6: index of the `proc_out` bit that signals program completion.
- `CNT_W`, 16: width of the run-cycle counter and limit.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `word_valid` in 1: instruction word offered.
- `word_ready` out 1: sequencer accepts `word_data` this cycle.
- `word_data` in `INSTR_W`: instruction, bit 0 = ctrl bit.
- `word_last` in 1: qualifies the final word of a program.
- `run_limit` in `CNT_W`: cycle budget; 0 = unlimited.
- `abort` in 1: terminate the current load or run.
- `user_in` in 2: data forwarded to `proc_in` during run.
- `proc_out` in 7: processor `outReg`.
- `proc_en` out 1: processor `en`.
- `proc_reset` out 1: processor `reset`.
- `proc_in` out 2: processor `inReg`.
- `busy` out 1: state ≠ IDLE.
- `result` out 7: `proc_out` captured at stop.
- `result_valid` out 1: one-cycle pulse when `result` and `status` update.
- `status` out 3: 0 NONE, 1 HALTED, 2 TIMEOUT, 3 UNDERFLOW, 4 OVERFLOW, 5 ABORTED.
- `cycles` out `CNT_W`: executed run cycles of the last program.

## Operation
- **States:** IDLE, LOAD, RUN, DONE.
- **IDLE:**
  - `proc_reset`=1, `proc_en`=0, `proc_in`=0, `word_ready`=1.
  - Holding the processor in reset clears its PC, registers and instruction memory.
  - On `word_valid`: latch the word into the shift register, latch `word_last`, latch `run_limit`, clear `cycles`, set word count = 1, then go to LOAD.
- **LOAD:**
  - `proc_reset`=0, `proc_en`=1, `proc_in[0]`=shift[0], `proc_in[1]`=0.
  - The shift register shifts right once per cycle and `bit_cnt` counts 0..`INSTR_W`-1.
  - `word_ready`=1 only while `bit_cnt`=`INSTR_W`-1 and the current word is not last.
  - At `bit_cnt`=`INSTR_W`-1, one of the following applies:
    - Current word is last: go to RUN.
    - Handshake occurs: load the next word, `bit_cnt`=0, stream continues with no gap.
    - No `word_valid`: status UNDERFLOW, go to DONE.
  - A handshake that would make word count exceed `MEM_DEPTH`: status OVERFLOW, go to DONE.
- **RUN:**
  - `proc_en`=0, `proc_reset`=0, `proc_in`=`user_in`.
  - `cycles` increments every cycle.
  - Stop when `proc_out[HALT_BIT]`=1 (status HALTED), or when `run_limit`≠0 and `cycles`+1 = `run_limit` (status TIMEOUT).
  - If both stop conditions occur in the same cycle, HALTED wins.
- **DONE (one cycle):**
  - `result`←`proc_out`, `result_valid`=1, `proc_reset`=1, then go to IDLE.
- **`abort`** in LOAD or RUN: status ABORTED, go to DONE. `abort` in IDLE or DONE is ignored.
- `result`, `status` and `cycles` hold their values until the next DONE.

## Timing
- All outputs are registered except `word_ready`, which is decoded from the registered state and `bit_cnt`.
- **Reset values:**
  - `proc_reset`=1, `proc_en`=0, `proc_in`=0.
  - `busy`=0, `result`=0, `result_valid`=0, `status`=0, `cycles`=0.
  - State = IDLE.
- **Load latency:**
  - First handshake at cycle t.
  - Bit 0 is on `proc_in[0]` with `proc_en`=1 in cycle t+1.
  - Word k (0-based) bit b appears in cycle t+1+13k+b.
- An N-word program occupies exactly 13N LOAD cycles. The first RUN cycle is t+1+13N.
- The `proc_en` rising edge occurs once per program, at LOAD entry. This restarts the processor's load counters at address 0.
- A stop detected in RUN cycle r is followed by DONE at r+1 and IDLE at r+2. `cycles` = number of RUN cycles completed, including r.
- A new program may be accepted in the first IDLE cycle.
- `reset` mid-load or mid-run forces IDLE next edge. No `result_valid` pulse is issued.

## Structure
- `obp_pkg`:
  - `INSTR_W`.
  - State enum `obp_state_t`.
  - Status codes `OBP_ST_*`.
  - The all-zero NOP/halt word constant.
- Sub-module `obp_serializer`:
  - Contents: `INSTR_W` shift register, `bit_cnt`, and `load`/`shift`/`bit_last` signals.
  - It is instantiated once.
  - The top module holds the FSM, word counter, cycle counter and capture registers.

## Test plan
- **2-word load, words 0x1A35 then 0x0001 (`word_last`):**
  - `proc_en` is high for exactly 26 cycles.
  - The `proc_in[0]` sequence equals the LSB-first bits of each word.
  - `word_ready` pulses once during LOAD.
- **Halt:**
  - Stimulus: `run_limit`=100; the bench processor model raises `proc_out[6]` in RUN cycle 5, with `proc_out`=0x41.
  - Response: `result_valid` pulse, `result`=0x41, `status`=1, `cycles`=5, `proc_reset`=1 in the same DONE cycle.
- **Timeout:** `run_limit`=10 with no halt -> `status`=2, `cycles`=10. With `run_limit`=0, the run continues until halt.
- **Underflow:** `word_valid` is low at the first word boundary without `word_last` -> `status`=3, `proc_en`=0 and `proc_reset`=1 within 2 cycles.
- **Overflow:** with `MEM_DEPTH`=4, offer 5 words with no `word_last` -> `status`=4 after word 4 shifts, and the fifth word is not accepted.
- **Abort and reset:**
  - `abort` in RUN cycle 3 -> `status`=5, `cycles`=3.
  - `reset` mid-LOAD -> IDLE next cycle, no `result_valid`, and a fresh 1-word load then runs normally.
